fetch_unit: RTL and testbench

- Instruction-fetch control stage of the 5-stage RISC-V pipeline, wrapped around the PC register.
- Consumes the current PC from the PC register and generates the next-PC value that the PC register loads every cycle.
- Issues instruction-memory requests with a valid/ready handshake, accepts variable-latency responses, and presents one instruction and its PC to the IF/ID stage.
- Squashes stale fetches on a branch/jump redirect.

---
 rtl/fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch control stage wrapped around the PC register.
//
// Works out the next PC for the PC register to load each cycle. Issues
// instruction-memory requests with a valid/ready handshake, with at most one
// request outstanding at a time. Waits for a response of variable latency and
// presents one instruction, with its PC, to the IF/ID stage. A redirect squashes
// any stale fetch or buffered instruction.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   pc_cur           current PC from the PC register output
//   pc_next          next PC, wired to the PC register input (loaded every cycle)
//   redirect_valid   taken branch/jump resolved this cycle
//   redirect_pc      redirect target (low two bits are cleared)
//   imem_req_*       fetch request channel (valid/ready, address = pc_cur)
//   imem_rsp_*       fetch response channel (valid, instruction word)
//   if_valid/ready   handshake with the decode stage
//   if_pc, if_instr  presented instruction and its PC
module fetch_unit #(
  parameter int unsigned           PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] pc_cur,
  output logic [PC_WIDTH-1:0] pc_next,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [PC_WIDTH-1:0] imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [PC_WIDTH-1:0] imem_rsp_data,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [PC_WIDTH-1:0] if_pc,
  output logic [PC_WIDTH-1:0] if_instr
);

  // REQ: idle with an empty buffer; WAIT: response pending;
  // DROP: the pending response is stale; HOLD: instruction buffered for decode.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(3'd4);

  fetch_state_t        state_r;
  logic [PC_WIDTH-1:0] req_pc_r;
  logic                if_valid_r;
  logic [PC_WIDTH-1:0] if_pc_r;
  logic [PC_WIDTH-1:0] if_instr_r;

  logic                req_valid_s;
  logic                handshake_s;
  logic [PC_WIDTH-1:0] redirect_target_s;

  assign redirect_target_s = {redirect_pc[PC_WIDTH-1:2], 2'b00};

  // Request issue and handshake detection. A redirect suppresses the request so
  // that the wrong-path PC is never sent to memory.
  always_comb begin
    req_valid_s = 1'b0;
    if (rst) begin
      req_valid_s = 1'b0;
    end else if (redirect_valid) begin
      req_valid_s = 1'b0;
    end else if ((state_r == ST_REQ) || ((state_r == ST_HOLD) && if_ready)) begin
      req_valid_s = 1'b1;
    end else begin
      req_valid_s = 1'b0;
    end
    handshake_s = req_valid_s && imem_req_ready;
  end

  // Next-PC selection. The priority order is reset, redirect, sequential step,
  // then hold. The sequential step wraps modulo 2^PC_WIDTH.
  always_comb begin
    pc_next = pc_cur;
    if (rst) begin
      pc_next = RESET_PC;
    end else if (redirect_valid) begin
      pc_next = redirect_target_s;
    end else if (handshake_s) begin
      pc_next = pc_cur + PC_STEP;
    end else begin
      pc_next = pc_cur;
    end
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = pc_cur;
  assign if_valid       = if_valid_r;
  assign if_pc          = if_pc_r;
  assign if_instr       = if_instr_r;

  // Fetch control FSM. It tracks the request PC and holds the decode-facing
  // buffer. Any response outside WAIT or DROP is a protocol error and is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_REQ;
      req_pc_r   <= '0;
      if_valid_r <= 1'b0;
      if_pc_r    <= '0;
      if_instr_r <= '0;
    end else begin
      case (state_r)
        ST_REQ: begin
          if (handshake_s) begin
            state_r  <= ST_WAIT;
            req_pc_r <= pc_cur;
          end else begin
            state_r  <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (redirect_valid) begin
            // A response in the same cycle is discarded. Otherwise the response
            // still to come must be dropped.
            state_r <= imem_rsp_valid ? ST_REQ : ST_DROP;
          end else if (imem_rsp_valid) begin
            state_r    <= ST_HOLD;
            if_valid_r <= 1'b1;
            if_pc_r    <= req_pc_r;
            if_instr_r <= imem_rsp_data;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_DROP: begin
          if (imem_rsp_valid) begin
            state_r <= ST_REQ;
          end else begin
            state_r <= ST_DROP;
          end
        end
        ST_HOLD: begin
          if (redirect_valid) begin
            // The buffered instruction is flushed, not consumed.
            state_r    <= ST_REQ;
            if_valid_r <= 1'b0;
          end else if (if_ready && handshake_s) begin
            state_r    <= ST_WAIT;
            req_pc_r   <= pc_cur;
            if_valid_r <= 1'b0;
          end else if (if_ready) begin
            state_r    <= ST_REQ;
            if_valid_r <= 1'b0;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          state_r    <= ST_REQ;
          if_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit. A small PC register model closes
// the pc_next -> pc_cur loop, and an override lets a test force arbitrary PCs.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  logic [31:0] pc_reg;
  logic        pc_ovr_en;
  logic [31:0] pc_ovr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // PC register model: loads pc_next on every rising edge.
  always @(posedge clk) pc_reg <= pc_next;
  assign pc_cur = pc_ovr_en ? pc_ovr : pc_reg;

  fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_next(pc_next),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr)
  );

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; if_ready = 1'b0;
    pc_ovr_en = 1'b0; pc_ovr = 32'h0;
    tick(); tick();
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b exp 0", imem_req_valid); end
    n_cmp++; if (pc_next !== 32'h0) begin n_bad++; $display("FAIL reset_pc_next: got %h exp 00000000", pc_next); end
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL reset_if_valid: got %b exp 0", if_valid); end
    n_cmp++; if (if_pc !== 32'h0 || if_instr !== 32'h0) begin n_bad++; $display("FAIL reset_if_regs: got pc %h instr %h exp 0/0", if_pc, if_instr); end
    rst = 1'b0;
  endtask

  task automatic test_basic_fetch();
    imem_req_ready = 1'b1; if_ready = 1'b1;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL basic_req_valid: got %b exp 1", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL basic_req_addr: got %h exp 00000000", imem_req_addr); end
    n_cmp++; if (pc_next !== 32'h4) begin n_bad++; $display("FAIL basic_pc_next: got %h exp 00000004", pc_next); end
    tick();
    // WAIT: no new request; the response arrives now.
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL wait_no_req: got %b exp 0", imem_req_valid); end
    n_cmp++; if (pc_next !== 32'h4) begin n_bad++; $display("FAIL wait_pc_hold: got %h exp 00000004", pc_next); end
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL basic_if_valid: got %b exp 1", if_valid); end
    n_cmp++; if (if_pc !== 32'h0) begin n_bad++; $display("FAIL basic_if_pc: got %h exp 00000000", if_pc); end
    n_cmp++; if (if_instr !== 32'h0000_0013) begin n_bad++; $display("FAIL basic_if_instr: got %h exp 00000013", if_instr); end
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin n_bad++; $display("FAIL b2b_req: got v %b addr %h exp 1/00000004", imem_req_valid, imem_req_addr); end
    n_cmp++; if (pc_next !== 32'h8) begin n_bad++; $display("FAIL b2b_pc_next: got %h exp 00000008", pc_next); end
  endtask

  task automatic test_back_to_back();
    tick();
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_if_drop: got %b exp 0", if_valid); end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093;
    tick();
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b0;
    #1;
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'h0010_0093) begin n_bad++; $display("FAIL b2b_second: got v %b pc %h instr %h exp 1/00000004/00100093", if_valid, if_pc, if_instr); end
    n_cmp++; if (pc_next !== 32'h8) begin n_bad++; $display("FAIL hold_noready_pc: got %h exp 00000008", pc_next); end
    tick();
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL hold_consume: got %b exp 0", if_valid); end
  endtask

  task automatic test_req_stall();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8 || pc_next !== 32'h8) begin n_bad++; $display("FAIL stall_%0d: got v %b addr %h next %h exp 1/00000008/00000008", i, imem_req_valid, imem_req_addr, pc_next); end
      tick();
    end
    imem_req_ready = 1'b1;
    #1;
    n_cmp++; if (pc_next !== 32'hC) begin n_bad++; $display("FAIL stall_release_pc: got %h exp 0000000c", pc_next); end
    tick();
    n_cmp++; if (imem_req_valid !== 1'b0 || pc_cur !== 32'hC) begin n_bad++; $display("FAIL stall_wait: got v %b pc %h exp 0/0000000c", imem_req_valid, pc_cur); end
  endtask

  task automatic test_redirect_drop();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    n_cmp++; if (pc_next !== 32'h100 || imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL redir_pc: got next %h v %b exp 00000100/0", pc_next, imem_req_valid); end
    tick();
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0 || pc_next !== 32'h100) begin n_bad++; $display("FAIL drop_idle: got v %b next %h exp 0/00000100", imem_req_valid, pc_next); end
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL drop_no_req: got %b exp 0", imem_req_valid); end
    tick();
    imem_rsp_valid = 1'b0; if_ready = 1'b0;
    #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL drop_discard: got %b exp 0", if_valid); end
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 || pc_next !== 32'h104) begin n_bad++; $display("FAIL drop_next_req: got v %b addr %h next %h exp 1/00000100/00000104", imem_req_valid, imem_req_addr, pc_next); end
    tick();
  endtask

  task automatic test_hold_stall();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFE_F00D;
    tick();
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL hold_stable_%0d: got v %b pc %h instr %h exp 1/00000100/cafef00d", i, if_valid, if_pc, if_instr); end
      n_cmp++; if (imem_req_valid !== 1'b0 || pc_next !== 32'h104) begin n_bad++; $display("FAIL hold_noreq_%0d: got v %b next %h exp 0/00000104", i, imem_req_valid, pc_next); end
      tick();
    end
    if_ready = 1'b1;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h104 || pc_next !== 32'h108) begin n_bad++; $display("FAIL hold_release: got v %b addr %h next %h exp 1/00000104/00000108", imem_req_valid, imem_req_addr, pc_next); end
    tick();
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL hold_release_drop: got %b exp 0", if_valid); end
  endtask

  task automatic test_redirect_with_rsp();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111;
    #1;
    n_cmp++; if (pc_next !== 32'h200 || imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL redir_rsp_pc: got next %h v %b exp 00000200/0", pc_next, imem_req_valid); end
    tick();
    redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL redir_rsp_discard: got %b exp 0", if_valid); end
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin n_bad++; $display("FAIL redir_rsp_req: got v %b addr %h exp 1/00000200", imem_req_valid, imem_req_addr); end
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h2222_2222; if_ready = 1'b0;
    tick();
    imem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset_in_hold();
    #1;
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== 32'h2222_2222) begin n_bad++; $display("FAIL prehold: got v %b pc %h instr %h exp 1/00000200/22222222", if_valid, if_pc, if_instr); end
    rst = 1'b1;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0 || pc_next !== 32'h0) begin n_bad++; $display("FAIL rst_hold_comb: got v %b next %h exp 0/00000000", imem_req_valid, pc_next); end
    tick();
    rst = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h3333_3333;
    #1;
    n_cmp++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin n_bad++; $display("FAIL rst_hold_regs: got v %b pc %h instr %h exp 0/0/0", if_valid, if_pc, if_instr); end
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rst_stale_rsp: got %b exp 0", if_valid); end
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL rst_req: got v %b addr %h exp 1/00000000", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_pc_wrap();
    pc_ovr_en = 1'b1; pc_ovr = 32'hFFFF_FFFC; imem_req_ready = 1'b1; if_ready = 1'b1;
    #1;
    n_cmp++; if (imem_req_addr !== 32'hFFFF_FFFC || pc_next !== 32'h0) begin n_bad++; $display("FAIL wrap: got addr %h next %h exp fffffffc/00000000", imem_req_addr, pc_next); end
    tick();
    pc_ovr_en = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h4444_4444;
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_instr !== 32'h4444_4444) begin n_bad++; $display("FAIL wrap_if: got v %b pc %h instr %h exp 1/fffffffc/44444444", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_redirect_in_hold();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0302;
    #1;
    n_cmp++; if (pc_next !== 32'h300 || imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL hold_redir: got next %h v %b exp 00000300/0", pc_next, imem_req_valid); end
    tick();
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL hold_redir_squash: got %b exp 0", if_valid); end
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin n_bad++; $display("FAIL hold_redir_req: got v %b addr %h exp 1/00000300", imem_req_valid, imem_req_addr); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_back_to_back();
    test_req_stall();
    test_redirect_drop();
    test_hold_stall();
    test_redirect_with_rsp();
    test_reset_in_hold();
    test_pc_wrap();
    test_redirect_in_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
